// File: rtl/code_lock_pkg.sv
// Shared types and constants for the keypad code lock controller.
package code_lock_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED,
        ST_ENTRY,
        ST_UNLOCKED,
        ST_ALARM
    } state_t;

    localparam logic [7:0] LED_OFF      = 8'h00;
    localparam logic [7:0] LED_UNLOCKED = 8'h01;

    // Bits needed to hold the values 0..n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int code_w(input int len, input int dw);
        return len * dw;
    endfunction

endpackage

// File: rtl/code_lock_if.sv
// Keypad/sensor inputs and lock/LED outputs of the code lock controller.
interface code_lock_if #(
    parameter int DIGIT_W = 4
) ();
    logic               digit_valid;
    logic [DIGIT_W-1:0] digit;
    logic               enter;
    logic               arm;
    logic               set_code;
    logic               sensor_open;
    logic               locked;
    logic               alarm;
    logic [2:0]         tries_left;
    logic [7:0]         led;

    modport master (
        output digit_valid, digit, enter, arm, set_code, sensor_open,
        input  locked, alarm, tries_left, led
    );

    modport slave (
        input  digit_valid, digit, enter, arm, set_code, sensor_open,
        output locked, alarm, tries_left, led
    );
endinterface

// File: rtl/blink_div.sv
// Alarm blink prescaler: blink toggles every DIV cycles; clr restarts it with blink high.
module blink_div
    import code_lock_pkg::*;
#(
    parameter int DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic blink
);
    localparam int            W    = cnt_w(DIV);
    localparam logic [W-1:0]  LOAD = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= LOAD;
            blink <= 1'b0;
        end else if (clr) begin
            cnt   <= LOAD;
            blink <= 1'b1;
        end else if (cnt == '0) begin
            cnt   <= LOAD;
            blink <= ~blink;
        end else begin
            cnt   <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/code_lock_ctrl.sv
// Keypad code lock: digit collection, code compare, attempt counting and alarm sequencing.
//
// state       | meaning
// ------------+--------------------------------------------------
// ST_LOCKED   | idle and locked, waiting for the first digit
// ST_ENTRY    | collecting digits, idle timeout running
// ST_UNLOCKED | open; digits may be collected to set a new code
// ST_ALARM    | intrusion or too many failures, LEDs blinking
module code_lock_ctrl
    import code_lock_pkg::*;
#(
    parameter int                            CODE_LEN     = 4,
    parameter int                            DIGIT_W      = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0]   DEFAULT_CODE = 16'h1234,
    parameter int                            MAX_TRIES    = 3,
    parameter int                            ENTRY_TO     = 250_000_000,
    parameter int                            BLINK_DIV    = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    code_lock_if.slave bus
);
    localparam int                CODE_W    = code_w(CODE_LEN, DIGIT_W);
    localparam int                CNT_W     = cnt_w(CODE_LEN);
    localparam int                TO_W      = cnt_w(ENTRY_TO);
    localparam logic [CNT_W-1:0]  FULL      = CNT_W'(CODE_LEN);
    localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(ENTRY_TO - 1);
    localparam logic [2:0]        TRIES_MAX = 3'(MAX_TRIES);

    state_t              state, state_nxt;
    logic [CODE_W-1:0]   code_q, code_nxt;
    logic [CODE_W-1:0]   buf_q, buf_nxt, buf_base;
    logic [CNT_W-1:0]    cnt_q, cnt_nxt, cnt_base;
    logic [TO_W-1:0]     to_q, to_nxt;
    logic [2:0]          tries_q, tries_nxt;
    logic                take_digit, clear_buf, digit_ok, match;
    logic                blink, blink_clr;

    // A digit that arrives together with enter is dropped.
    assign digit_ok = bus.digit_valid & ~bus.enter;
    assign match    = (cnt_q == FULL) && (buf_q == code_q);

    always_comb begin
        state_nxt  = state;
        code_nxt   = code_q;
        tries_nxt  = tries_q;
        to_nxt     = to_q;
        take_digit = 1'b0;
        clear_buf  = 1'b0;

        case (state)
            ST_LOCKED: begin
                if (bus.sensor_open) begin
                    state_nxt = ST_ALARM;
                end else if (digit_ok) begin
                    state_nxt  = ST_ENTRY;
                    take_digit = 1'b1;
                    to_nxt     = TO_LOAD;
                end
            end
            ST_ENTRY: begin
                if (bus.sensor_open) begin
                    state_nxt = ST_ALARM;
                end else if (bus.enter) begin
                    if (match) begin
                        state_nxt = ST_UNLOCKED;
                        tries_nxt = TRIES_MAX;
                    end else if (tries_q <= 3'd1) begin
                        state_nxt = ST_ALARM;
                        tries_nxt = 3'd0;
                    end else begin
                        state_nxt = ST_LOCKED;
                        tries_nxt = tries_q - 3'd1;
                    end
                end else if (digit_ok) begin
                    take_digit = 1'b1;
                    to_nxt     = TO_LOAD;
                end else if (to_q == '0) begin
                    state_nxt = ST_LOCKED;
                end else begin
                    to_nxt = to_q - 1'b1;
                end
            end
            ST_UNLOCKED: begin
                if (bus.set_code) begin
                    if (cnt_q == FULL) begin
                        code_nxt  = buf_q;
                        clear_buf = 1'b1;
                    end
                end else if (bus.arm) begin
                    if (!bus.sensor_open) state_nxt = ST_LOCKED;
                end else if (digit_ok) begin
                    take_digit = 1'b1;
                end
            end
            ST_ALARM: begin
                if (bus.enter) begin
                    if (match) begin
                        state_nxt = ST_UNLOCKED;
                        tries_nxt = TRIES_MAX;
                    end else begin
                        clear_buf = 1'b1;
                    end
                end else if (digit_ok) begin
                    take_digit = 1'b1;
                end
            end
            default: state_nxt = ST_LOCKED;
        endcase

        // Any state change wipes the buffer; the digit that opens ENTRY is kept.
        if ((state_nxt != state) || clear_buf) begin
            buf_base = '0;
            cnt_base = '0;
        end else begin
            buf_base = buf_q;
            cnt_base = cnt_q;
        end
        buf_nxt = buf_base;
        cnt_nxt = cnt_base;
        if (take_digit) begin
            buf_nxt = (buf_base << DIGIT_W) | CODE_W'(bus.digit);
            cnt_nxt = (cnt_base == FULL) ? FULL : cnt_base + 1'b1;
        end
    end

    assign blink_clr = (state_nxt == ST_ALARM) && (state != ST_ALARM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_LOCKED;
            code_q  <= DEFAULT_CODE;
            buf_q   <= '0;
            cnt_q   <= '0;
            to_q    <= TO_LOAD;
            tries_q <= TRIES_MAX;
        end else begin
            state   <= state_nxt;
            code_q  <= code_nxt;
            buf_q   <= buf_nxt;
            cnt_q   <= cnt_nxt;
            to_q    <= to_nxt;
            tries_q <= tries_nxt;
        end
    end

    blink_div #(.DIV(BLINK_DIV)) u_blink (
        .clk   (clk),
        .rst   (rst),
        .clr   (blink_clr),
        .blink (blink)
    );

    assign bus.locked     = (state == ST_LOCKED) || (state == ST_ENTRY);
    assign bus.alarm      = (state == ST_ALARM);
    assign bus.tries_left = tries_q;

    always_comb begin
        case (state)
            ST_ALARM:    bus.led = {8{blink}};
            ST_UNLOCKED: bus.led = LED_UNLOCKED;
            default:     bus.led = LED_OFF;
        endcase
    end
endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed self-checking bench for code_lock_ctrl with short blink and timeout periods.
module tb_code_lock_ctrl;
    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    code_lock_if #(.DIGIT_W(4)) bus ();

    code_lock_ctrl #(
        .CODE_LEN     (4),
        .DIGIT_W      (4),
        .DEFAULT_CODE (16'h1234),
        .MAX_TRIES    (3),
        .ENTRY_TO     (16),
        .BLINK_DIV    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic lk, input logic al,
                               input logic [2:0] tr, input logic [7:0] ld);
        check({tag, ".locked"}, {7'd0, bus.locked}, {7'd0, lk});
        check({tag, ".alarm"}, {7'd0, bus.alarm}, {7'd0, al});
        check({tag, ".tries"}, {5'd0, bus.tries_left}, {5'd0, tr});
        check({tag, ".led"}, bus.led, ld);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        bus.digit       = d;
        bus.digit_valid = 1'b1;
        tick();
        bus.digit_valid = 1'b0;
    endtask

    task automatic do_enter();
        bus.enter = 1'b1;
        tick();
        bus.enter = 1'b0;
    endtask

    task automatic do_arm();
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
    endtask

    task automatic do_set_code();
        bus.set_code = 1'b1;
        tick();
        bus.set_code = 1'b0;
    endtask

    task automatic try_code(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
        press(a);
        press(b);
        press(c);
        press(d);
        do_enter();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp_led;
        rst             = 1'b1;
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
        bus.enter       = 1'b0;
        bus.arm         = 1'b0;
        bus.set_code    = 1'b0;
        bus.sensor_open = 1'b0;
        repeat (3) tick();
        check_state("reset", 1'b1, 1'b0, 3'd3, 8'h00);
        rst = 1'b0;
        tick();

        try_code(4'd1, 4'd2, 4'd3, 4'd4);
        check_state("unlock", 1'b0, 1'b0, 3'd3, 8'h01);
        do_arm();
        check_state("arm_lock", 1'b1, 1'b0, 3'd3, 8'h00);

        // Three wrong codes run the attempt counter down into the alarm.
        try_code(4'd1, 4'd2, 4'd3, 4'd5);
        check_state("bad1", 1'b1, 1'b0, 3'd2, 8'h00);
        try_code(4'd1, 4'd2, 4'd3, 4'd5);
        check_state("bad2", 1'b1, 1'b0, 3'd1, 8'h00);
        try_code(4'd1, 4'd2, 4'd3, 4'd5);
        check_state("bad3", 1'b0, 1'b1, 3'd0, 8'hFF);
        for (int i = 0; i < 12; i++) begin
            exp_led = ((i % 8) < 4) ? 8'hFF : 8'h00;
            check("blink", bus.led, exp_led);
            tick();
        end
        try_code(4'd1, 4'd2, 4'd3, 4'd4);
        check_state("alarm_unlock", 1'b0, 1'b0, 3'd3, 8'h01);

        do_arm();
        bus.sensor_open = 1'b1;
        tick();
        bus.sensor_open = 1'b0;
        check_state("sensor_alarm", 1'b0, 1'b1, 3'd3, 8'hFF);
        try_code(4'd1, 4'd2, 4'd3, 4'd4);
        check_state("sensor_unlock", 1'b0, 1'b0, 3'd3, 8'h01);

        // New code 9876; a set_code with one digit buffered must not overwrite it.
        press(4'd9);
        press(4'd8);
        press(4'd7);
        press(4'd6);
        do_set_code();
        check_state("set_code", 1'b0, 1'b0, 3'd3, 8'h01);
        press(4'd5);
        do_set_code();
        bus.sensor_open = 1'b1;
        do_arm();
        bus.sensor_open = 1'b0;
        check_state("arm_open", 1'b0, 1'b0, 3'd3, 8'h01);
        do_arm();
        check_state("arm_new", 1'b1, 1'b0, 3'd3, 8'h00);
        try_code(4'd1, 4'd2, 4'd3, 4'd4);
        check_state("old_code", 1'b1, 1'b0, 3'd2, 8'h00);
        try_code(4'd9, 4'd8, 4'd7, 4'd6);
        check_state("new_code", 1'b0, 1'b0, 3'd3, 8'h01);

        // Entry abandoned after 16 idle cycles: a later enter is ignored in LOCKED.
        do_arm();
        press(4'd1);
        repeat (16) tick();
        do_enter();
        check_state("timeout", 1'b1, 1'b0, 3'd3, 8'h00);
        press(4'd1);
        repeat (14) tick();
        do_enter();
        check_state("pre_timeout", 1'b1, 1'b0, 3'd2, 8'h00);

        bus.sensor_open = 1'b1;
        tick();
        bus.sensor_open = 1'b0;
        check_state("alarm_again", 1'b0, 1'b1, 3'd2, 8'hFF);
        #3;
        rst = 1'b1;
        #1;
        check_state("rst_alarm", 1'b1, 1'b0, 3'd3, 8'h00);
        rst = 1'b0;
        tick();
        try_code(4'd1, 4'd2, 4'd3, 4'd4);
        check_state("default_after_rst1", 1'b0, 1'b0, 3'd3, 8'h01);

        do_arm();
        try_code(4'd1, 4'd2, 4'd3, 4'd5);
        check_state("bad_before_rst", 1'b1, 1'b0, 3'd2, 8'h00);
        press(4'd1);
        press(4'd2);
        #3;
        rst = 1'b1;
        #1;
        check_state("rst_entry", 1'b1, 1'b0, 3'd3, 8'h00);
        rst = 1'b0;
        tick();
        try_code(4'd1, 4'd2, 4'd3, 4'd4);
        check_state("default_after_rst2", 1'b0, 1'b0, 3'd3, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/code_lock_ctrl.md
# code_lock_ctrl

Sequencing controller for the board's door-lock/alarm LED bank. Collects keypad digits, compares them against a stored code, and drives the lock state machine: locked, unlocked, intrusion alarm, failed-attempt counting. Owns the blink prescaler that flashes all eight LEDs in alarm. Sits between the debounced button/keypad front end and the LED outputs.

## Interface
- CODE_LEN, 4: digits per code.
- DIGIT_W, 4: bits per digit.
- DEFAULT_CODE, 16'h1234: stored code after reset (CODE_LEN*DIGIT_W bits, first digit in MSBs).
- MAX_TRIES, 3: wrong entries tolerated before alarm (1..7).
- ENTRY_TO, 250_000_000: idle cycles in ENTRY before abandoning.
- BLINK_DIV, 25_000_000: cycles per LED half-period.

- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- digit_valid  in  1  one-cycle strobe, digit valid.
- digit  in  DIGIT_W  keypad value.
- enter  in  1  one-cycle strobe, check code.
- arm  in  1  one-cycle strobe, lock request.
- set_code  in  1  one-cycle strobe, store new code.
- sensor_open  in  1  door-open level (synchronised upstream).
- locked  out  1  high in LOCKED or ENTRY.
- alarm  out  1  high in ALARM.
- tries_left  out  3  remaining attempts.
- led  out  8  LED bank.

## Operation
- States: LOCKED, ENTRY, UNLOCKED, ALARM. Reset: LOCKED, code = DEFAULT_CODE, buffer cleared, digit count 0, tries_left = MAX_TRIES, locked=1, alarm=0, led=0.
- Digit buffer: shift left by DIGIT_W on each accepted digit, keeps last CODE_LEN digits; count saturates at CODE_LEN. Buffer and count are cleared on every state change.
- Match: count == CODE_LEN and buffer == stored code.
- LOCKED: sensor_open -> ALARM. digit_valid -> ENTRY, accepting that digit.
- ENTRY: sensor_open -> ALARM. digit_valid -> accept digit, restart timeout. enter with match -> UNLOCKED, tries_left = MAX_TRIES. enter without match -> tries_left-1; if the result is 0 -> ALARM, else -> LOCKED. ENTRY_TO cycles with no digit -> LOCKED; no try is consumed.
- UNLOCKED: digits accepted into the buffer. set_code with count == CODE_LEN -> stored code = buffer, buffer cleared, state unchanged; set_code with a short count is ignored. arm with sensor_open=0 -> LOCKED; arm with sensor_open=1 is ignored.
- ALARM: digits accepted. enter with match -> UNLOCKED, tries_left = MAX_TRIES. enter without match clears the buffer and the state stays ALARM. Otherwise only rst exits.
- Priority in one cycle: rst > sensor_open (LOCKED/ENTRY) > enter > set_code > arm > digit_valid. A digit arriving together with enter is dropped.
- Strobes not listed for a state are ignored.
- LEDs: ALARM -> all eight = blink. UNLOCKED -> led = 8'h01. Other states -> 8'h00.

## Timing
- All outputs are registered. A strobe sampled on edge N is reflected in the outputs after edge N.
- Blink: counter 0..BLINK_DIV-1, toggles blink on wrap. On ALARM entry the counter clears and blink = 1, so LEDs are on for the first BLINK_DIV cycles of ALARM, then off for BLINK_DIV cycles, and so on.
- Timeout counter clears on ENTRY entry and on each accepted digit. The ENTRY_TO-th idle cycle triggers the exit.
- Asynchronous rst mid-entry or mid-alarm forces reset values immediately. The stored code reverts to DEFAULT_CODE.

## Structure
- code_lock_pkg: state enum, DIGIT_W/CODE_LEN-derived width constants, LED pattern constants.
- Sub-module blink_div: prescaler with sync clear, output blink. The FSM, buffer, tries counter and timeout live in the top module.

## Test plan
Parameters for all scenarios: BLINK_DIV=4, ENTRY_TO=16, MAX_TRIES=3.
- Digits 1,2,3,4 then enter -> UNLOCKED; led=8'h01, locked=0, tries_left=3.
- Three entries of 1,2,3,5 + enter -> tries_left 2, then 1, then ALARM; led toggles 8'hFF/8'h00 every 4 cycles, starting 8'hFF.
- sensor_open=1 while LOCKED -> alarm=1 the next cycle. Then 1,2,3,4 + enter -> UNLOCKED.
- In UNLOCKED: digits 9,8,7,6 + set_code, then arm with sensor_open=0 -> LOCKED. Entering 1,2,3,4 fails (tries_left=2); 9,8,7,6 unlocks.
- Digit 1, then 16 idle cycles -> back to LOCKED, tries_left unchanged at 3. Also: arm while sensor_open=1 in UNLOCKED -> stays UNLOCKED.
- rst asserted mid-ALARM and mid-ENTRY -> led=0, locked=1, tries_left=3 immediately; DEFAULT_CODE works again.
